vga_console_ctrl: RTL and testbench



---
 rtl/vga_console_pkg.sv | 30 +++
 rtl/vga_console_addr.sv | 30 +++
 rtl/vga_console_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants, control codes and FSM state type for the text-console sequencer.
package vga_console_pkg;

    localparam int N_COL          = 80;
    localparam int N_ROW          = 30;
    localparam int CHAR_WIDTH     = 7;
    localparam int BUF_ADDR_WIDTH = 10;
    localparam int WORDS_PER_ROW  = N_COL / 4;
    localparam int BUF_WORDS      = N_ROW * N_COL / 4;

    localparam logic [CHAR_WIDTH-1:0] BLANK_CHAR = 7'h20;
    localparam logic [6:0] CC_CR    = 7'h0D;
    localparam logic [6:0] CC_LF    = 7'h0A;
    localparam logic [6:0] CC_BS    = 7'h08;
    localparam logic [6:0] CC_FF    = 7'h0C;
    localparam logic [6:0] PRINT_LO = 7'h20;
    localparam logic [6:0] PRINT_HI = 7'h7E;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_CLEAR_LINE = 2'd2,
        ST_CLEAR_ALL  = 2'd3
    } state_e;

    function automatic logic [4:0] next_top(input logic [4:0] top);
        return (top == 5'(N_ROW - 1)) ? 5'd0 : top + 5'd1;
    endfunction

endpackage

// File: rtl/vga_console_addr.sv
// Maps a logical cursor position plus the rotating top-row offset onto a
// buffer word address and a one-hot lane strobe.
module vga_console_addr
    import vga_console_pkg::*;
(
    input  logic [4:0]                row_i,
    input  logic [6:0]                col_i,
    input  logic [4:0]                top_row_i,
    output logic [4:0]                phys_row_o,
    output logic [BUF_ADDR_WIDTH-1:0] w_addr_o,
    output logic [3:0]                w_strb_o
);

    logic [5:0]  row_sum_s;
    logic [11:0] tile_s;

    // Row rotation, then tile = phys_row*80 + col built from shifts.
    always_comb begin
        row_sum_s = {1'b0, row_i} + {1'b0, top_row_i};
        if (row_sum_s >= 6'(N_ROW)) begin
            phys_row_o = 5'(row_sum_s - 6'(N_ROW));
        end else begin
            phys_row_o = row_sum_s[4:0];
        end
        tile_s   = ({7'd0, phys_row_o} << 6) + ({7'd0, phys_row_o} << 4) + {5'd0, col_i};
        w_addr_o = tile_s[11:2];
        w_strb_o = 4'b0001 << tile_s[1:0];
    end

endmodule

// File: rtl/vga_console_ctrl.sv
// Byte-stream text console: cursor tracking, control codes, wrap and
// offset-based scrolling, yielding the buffer write port to AXI traffic.
module vga_console_ctrl
    import vga_console_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      char_valid_i,
    input  logic [7:0]                char_data_i,
    output logic                      char_ready_o,
    input  logic                      axi_busy_i,
    output logic                      wr_en_o,
    output logic [BUF_ADDR_WIDTH-1:0] w_addr_o,
    output logic [4*CHAR_WIDTH-1:0]   w_data_o,
    output logic [3:0]                w_strb_o,
    output logic [4:0]                cursor_row_o,
    output logic [6:0]                cursor_col_o,
    output logic [4:0]                top_row_o
);

    state_e                  state_q;
    logic [9:0]              cnt_q;
    logic [4:0]              row_q;
    logic [6:0]              col_q;
    logic [4:0]              top_q;
    logic [CHAR_WIDTH-1:0]   char_q;
    logic                    adv_q;

    logic [4:0]              phys_row_s;
    logic [9:0]              cur_addr_s;
    logic [3:0]              cur_strb_s;
    logic [9:0]              line_base_s;
    logic [6:0]              code_s;
    logic                    wr_fire_s;
    logic                    nl_scroll_s;
    logic [4:0]              nl_row_s;
    logic [4:0]              nl_top_s;
    logic                    unused_s;

    vga_console_addr u_addr (
        .row_i      (row_q),
        .col_i      (col_q),
        .top_row_i  (top_q),
        .phys_row_o (phys_row_s),
        .w_addr_o   (cur_addr_s),
        .w_strb_o   (cur_strb_s)
    );

    // During CLEAR_LINE the cursor's physical row is exactly the row being scrolled in.
    always_comb begin
        code_s      = char_data_i[6:0];
        unused_s    = char_data_i[7];
        wr_fire_s   = !rst_i && (state_q != ST_IDLE) && !axi_busy_i;
        line_base_s = ({5'd0, phys_row_s} << 4) + ({5'd0, phys_row_s} << 2);
        nl_scroll_s = (row_q == 5'(N_ROW - 1));
        nl_row_s    = nl_scroll_s ? row_q : row_q + 5'd1;
        nl_top_s    = nl_scroll_s ? next_top(top_q) : top_q;
    end

    // Write-port drive; wr_en follows axi_busy_i in the same cycle so AXI always wins.
    always_comb begin
        char_ready_o = !rst_i && (state_q == ST_IDLE);
        wr_en_o      = wr_fire_s;
        w_data_o     = {4{BLANK_CHAR}};
        w_strb_o     = 4'hF;
        case (state_q)
            ST_WRITE: begin
                w_addr_o = cur_addr_s;
                w_strb_o = cur_strb_s;
                w_data_o = {4{char_q}};
            end
            ST_CLEAR_LINE: w_addr_o = line_base_s + cnt_q;
            ST_CLEAR_ALL:  w_addr_o = cnt_q;
            default: begin
                w_addr_o = cur_addr_s;
                w_strb_o = 4'h0;
            end
        endcase
        cursor_row_o = row_q;
        cursor_col_o = col_q;
        top_row_o    = top_q;
    end

    // Console sequencer FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR_ALL;
            cnt_q   <= 10'd0;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
            top_q   <= 5'd0;
            char_q  <= BLANK_CHAR;
            adv_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (char_valid_i) begin
                        if (code_s >= PRINT_LO && code_s <= PRINT_HI) begin
                            char_q  <= code_s;
                            adv_q   <= 1'b1;
                            state_q <= ST_WRITE;
                        end else begin
                            case (code_s)
                                CC_CR: col_q <= 7'd0;
                                CC_LF: begin
                                    col_q   <= 7'd0;
                                    row_q   <= nl_row_s;
                                    top_q   <= nl_top_s;
                                    cnt_q   <= 10'd0;
                                    state_q <= nl_scroll_s ? ST_CLEAR_LINE : ST_IDLE;
                                end
                                CC_BS: begin
                                    if (col_q != 7'd0) begin
                                        col_q   <= col_q - 7'd1;
                                        char_q  <= BLANK_CHAR;
                                        adv_q   <= 1'b0;
                                        state_q <= ST_WRITE;
                                    end
                                end
                                CC_FF: begin
                                    row_q   <= 5'd0;
                                    col_q   <= 7'd0;
                                    top_q   <= 5'd0;
                                    cnt_q   <= 10'd0;
                                    state_q <= ST_CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_fire_s) begin
                        if (!adv_q) begin
                            state_q <= ST_IDLE;
                        end else if (col_q == 7'(N_COL - 1)) begin
                            col_q   <= 7'd0;
                            row_q   <= nl_row_s;
                            top_q   <= nl_top_s;
                            cnt_q   <= 10'd0;
                            state_q <= nl_scroll_s ? ST_CLEAR_LINE : ST_IDLE;
                        end else begin
                            col_q   <= col_q + 7'd1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_CLEAR_LINE: begin
                    if (wr_fire_s) begin
                        if (cnt_q == 10'(WORDS_PER_ROW - 1)) begin
                            cnt_q   <= 10'd0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                end
                ST_CLEAR_ALL: begin
                    if (wr_fire_s) begin
                        if (cnt_q == 10'(BUF_WORDS - 1)) begin
                            cnt_q   <= 10'd0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                end
                default: begin
                    cnt_q   <= 10'd0;
                    state_q <= ST_CLEAR_ALL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Scoreboard bench for vga_console_ctrl: a screen-level model predicts buffer
// writes and cursor state; a negedge monitor checks each write as it appears.
module tb_vga_console_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        char_valid_i = 1'b0;
    logic [7:0]  char_data_i = 8'h00;
    logic        force_busy = 1'b0;
    logic        rand_busy = 1'b0;
    logic        rand_en = 1'b0;
    logic        axi_busy_i;
    logic        char_ready_o;
    logic        wr_en_o;
    logic [9:0]  w_addr_o;
    logic [27:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic [4:0]  cursor_row_o;
    logic [6:0]  cursor_col_o;
    logic [4:0]  top_row_o;

    assign axi_busy_i = force_busy | rand_busy;

    vga_console_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .char_valid_i (char_valid_i),
        .char_data_i  (char_data_i),
        .char_ready_o (char_ready_o),
        .axi_busy_i   (axi_busy_i),
        .wr_en_o      (wr_en_o),
        .w_addr_o     (w_addr_o),
        .w_data_o     (w_data_o),
        .w_strb_o     (w_strb_o),
        .cursor_row_o (cursor_row_o),
        .cursor_col_o (cursor_col_o),
        .top_row_o    (top_row_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [9:0]  addr;
        logic [27:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t exp_q[$];
    int  compared = 0;
    int  failed = 0;
    int  m_row = 0, m_col = 0, m_top = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_write(input int row, input int col, input int top, input logic [6:0] ch);
        int  phys;
        int  tile;
        wr_t w;
        phys   = (row + top) % ROWS;
        tile   = phys * COLS + col;
        w.addr = 10'(tile / 4);
        w.data = {4{ch}};
        w.strb = 4'(1 << (tile % 4));
        exp_q.push_back(w);
    endfunction

    function automatic void push_clear(input int first, input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = 10'(first + i);
            w.data = {4{7'h20}};
            w.strb = 4'hF;
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_newline();
        m_col = 0;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            push_clear(m_top * (COLS / 4), COLS / 4);
            m_top = (m_top + 1) % ROWS;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int c;
        c = int'(b[6:0]);
        if (c >= 32 && c <= 126) begin
            push_write(m_row, m_col, m_top, b[6:0]);
            m_col++;
            if (m_col == COLS) model_newline();
        end else if (c == 13) begin
            m_col = 0;
        end else if (c == 10) begin
            model_newline();
        end else if (c == 8) begin
            if (m_col > 0) begin
                m_col--;
                push_write(m_row, m_col, m_top, 7'h20);
            end
        end else if (c == 12) begin
            m_row = 0;
            m_col = 0;
            m_top = 0;
            push_clear(0, ROWS * COLS / 4);
        end
    endfunction

    // Monitor: every buffer write must match the head of the expected queue.
    always @(negedge clk_i) begin
        wr_t e;
        if (rst_i) begin
            check("rst_wr_en", 32'(wr_en_o), 32'd0);
        end else begin
            if (axi_busy_i) check("busy_wr_en", 32'(wr_en_o), 32'd0);
            if (wr_en_o) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL unexpected_write: got addr 0x%0h strb 0x%0h, want no write", w_addr_o, w_strb_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(w_addr_o), 32'(e.addr));
                    check("wr_data", 32'(w_data_o), 32'(e.data));
                    check("wr_strb", 32'(w_strb_o), 32'(e.strb));
                end
            end
        end
    end

    // Random AXI contention, changed just after the active edge.
    always @(posedge clk_i) begin
        #1;
        rand_busy = rand_en && ($urandom_range(0, 3) == 0);
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(posedge clk_i); #1;
        char_valid_i = 1'b1;
        char_data_i  = b;
        while (!char_ready_o && t < 5000) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (!char_ready_o) begin
            compared++;
            failed++;
            $display("FAIL send_timeout: got ready 0, want 1 for byte 0x%0h", b);
            char_valid_i = 1'b0;
            return;
        end
        model_byte(b);
        @(posedge clk_i); #1;
        char_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (!char_ready_o && t < 5000) begin
            @(posedge clk_i); #1;
            t++;
        end
        check({name, "_ready"}, 32'(char_ready_o), 32'd1);
        check({name, "_row"}, 32'(cursor_row_o), 32'(m_row));
        check({name, "_col"}, 32'(cursor_col_o), 32'(m_col));
        check({name, "_top"}, 32'(top_row_o), 32'(m_top));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset(input string name);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        exp_q.delete();
        check({name, "_ready"}, 32'(char_ready_o), 32'd0);
        m_row = 0;
        m_col = 0;
        m_top = 0;
        push_clear(0, ROWS * COLS / 4);
        rst_i = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] b;
        int r;

        apply_reset("reset");

        send(8'h41);
        check("A_ready_n1", 32'(char_ready_o), 32'd0);
        check("A_wr_en_n1", 32'(wr_en_o), 32'd1);
        @(posedge clk_i); #1;
        check("A_ready_n2", 32'(char_ready_o), 32'd1);
        send(8'h42);
        wait_idle("AB");

        send(8'h0D);
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        wait_idle("last_row");
        for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32, 126)));
        wait_idle("row_full");
        send(8'h5A);
        t = 0;
        while (exp_q.size() > 13 && t < 200) begin
            @(negedge clk_i); #1;
            t++;
        end
        check("clear_word7_reached", 32'(exp_q.size()), 32'd13);
        @(posedge clk_i); #1;
        force_busy = 1'b1;
        repeat (5) @(posedge clk_i);
        check("scroll_top_held", 32'(top_row_o), 32'(m_top));
        #1;
        force_busy = 1'b0;
        wait_idle("scroll");

        for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
        send(8'h78);
        wait_idle("rotated_write");

        send(8'h0D);
        send(8'h08);
        check("bs0_ready", 32'(char_ready_o), 32'd1);
        check("bs0_wr_en", 32'(wr_en_o), 32'd0);
        wait_idle("bs_col0");

        for (int i = 0; i < 3; i++) send(8'($urandom_range(32, 126)));
        send(8'h08);
        wait_idle("bs_col3");

        send(8'h0A);
        send(8'h0C);
        wait_idle("form_feed");

        rand_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 92) b = 8'h08;
            else if (r < 94) b = 8'h0C;
            else             b = 8'($urandom_range(0, 31));
            b[7] = 1'($urandom_range(0, 1));
            send(b);
            wait_idle("rand");
        end
        rand_en = 1'b0;
        @(posedge clk_i); #1;

        while (m_row < ROWS - 1) send(8'h0A);
        wait_idle("pre_rst");
        send(8'h0A);
        repeat (5) @(posedge clk_i);
        #1;
        apply_reset("rst_midclear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
